// File: rtl/pulse_train_gen.sv
// Programmable multi-channel pulse-train sequencer: N pulses of H high / L low cycles on masked channels.
// Optional endless mode for N=0 is enabled by defining PULSE_TRAIN_CONTINUOUS_EN.
module pulse_train_gen #(
  parameter int CHANNELS = 4,
  parameter int LEN_W    = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [LEN_W-1:0]    high_len,
  input  logic [LEN_W-1:0]    low_len,
  input  logic [CNT_W-1:0]    pulse_cnt,
  input  logic [CHANNELS-1:0] ch_mask,
  output logic [CHANNELS-1:0] signal,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2} state_t;

  state_t              r_state;
  logic [LEN_W-1:0]    r_phase;
  logic [CNT_W-1:0]    r_left;
  logic [LEN_W-1:0]    r_high;
  logic [LEN_W-1:0]    r_low;
  logic [CHANNELS-1:0] r_mask;
  logic                r_cont;
  logic [CHANNELS-1:0] r_signal;
  logic                r_busy;
  logic                r_done;

  logic [LEN_W-1:0]    w_high_eff;
  logic [LEN_W-1:0]    w_low_eff;

  // Zero-length phases are stretched to one cycle.
  assign w_high_eff = (high_len == '0) ? LEN_W'(1) : high_len;
  assign w_low_eff  = (low_len  == '0) ? LEN_W'(1) : low_len;

  // r_phase holds the cycles remaining in the current phase after this one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_left   <= '0;
      r_high   <= '0;
      r_low    <= '0;
      r_mask   <= '0;
      r_cont   <= 1'b0;
      r_signal <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_high <= w_high_eff;
            r_low  <= w_low_eff;
            r_mask <= ch_mask;
            if (pulse_cnt != '0) begin
              r_state  <= S_HIGH;
              r_signal <= ch_mask;
              r_busy   <= 1'b1;
              r_phase  <= w_high_eff - LEN_W'(1);
              r_left   <= pulse_cnt - CNT_W'(1);
              r_cont   <= 1'b0;
            end else begin
`ifdef PULSE_TRAIN_CONTINUOUS_EN
              r_state  <= S_HIGH;
              r_signal <= ch_mask;
              r_busy   <= 1'b1;
              r_phase  <= w_high_eff - LEN_W'(1);
              r_left   <= '0;
              r_cont   <= 1'b1;
`else
              r_done   <= 1'b1;
              r_cont   <= 1'b0;
`endif
            end
          end
        end
        S_HIGH: begin
          if (stop) begin
            r_state  <= S_IDLE;
            r_signal <= '0;
            r_busy   <= 1'b0;
            r_phase  <= '0;
            r_left   <= '0;
          end else if (r_phase == '0) begin
            r_state  <= S_LOW;
            r_signal <= '0;
            r_phase  <= r_low - LEN_W'(1);
          end else begin
            r_phase <= r_phase - LEN_W'(1);
          end
        end
        S_LOW: begin
          if (stop) begin
            r_state  <= S_IDLE;
            r_signal <= '0;
            r_busy   <= 1'b0;
            r_phase  <= '0;
            r_left   <= '0;
          end else if (r_phase == '0) begin
            if (r_cont || (r_left != '0)) begin
              r_state  <= S_HIGH;
              r_signal <= r_mask;
              r_phase  <= r_high - LEN_W'(1);
              if (!r_cont) begin
                r_left <= r_left - CNT_W'(1);
              end
            end else begin
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end
          end else begin
            r_phase <= r_phase - LEN_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_signal <= '0;
          r_busy   <= 1'b0;
          r_phase  <= '0;
          r_left   <= '0;
        end
      endcase
    end
  end

  assign signal = r_signal;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
